i2s_frame_sched: RTL and testbench

Frame scheduler for the CS4334 I2S output path. It arbitrates stereo 16-bit samples from two sources (A: DDS generator, B: auxiliary/test source) through valid/ready handshakes and holds one stereo pair in a staging buffer. Once per LRCLK frame it commits the pair to the I2S transmitter through the transmitter's L_EN/L_DIN and R_EN/R_DIN load interface. It also handles source switching, mute and underrun accounting on frame boundaries.

---
 rtl/i2s_frame_sched.sv | 115 +++++++++++
 tb/tb_i2s_frame_sched.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/i2s_frame_sched.sv
// Frame scheduler for the CS4334 I2S path: arbitrates two stereo sources into a
// one-pair staging buffer and commits one pair per LRCLK frame to the transmitter.
module i2s_frame_sched #(
  parameter int unsigned DW      = 16,
  parameter bit          UR_HOLD = 1'b1
) (
  input  logic          MCLKIN,
  input  logic          RST,
  input  logic          LRCLK,
  input  logic          SRC_SEL,
  input  logic          MUTE,
  input  logic          A_VALID,
  input  logic [DW-1:0] A_L,
  input  logic [DW-1:0] A_R,
  input  logic          B_VALID,
  input  logic [DW-1:0] B_L,
  input  logic [DW-1:0] B_R,
  output logic          A_READY,
  output logic          B_READY,
  output logic          L_EN,
  output logic          R_EN,
  output logic [DW-1:0] L_DOUT,
  output logic [DW-1:0] R_DOUT,
  output logic          ACT_SRC,
  output logic          UNDERRUN,
  output logic [15:0]   UR_CNT
);

  typedef enum logic {FILL, FULL} state_t;

  state_t        state, state_nxt;
  logic          lr_q, lr_vld;
  logic          e, rdy, hs;
  logic          armed;
  logic [DW-1:0] buf_l, buf_r, last_l, last_r;
  logic [DW-1:0] com_l, com_r;
  logic [15:0]   ur_cnt;

  assign UR_CNT = ur_cnt;

  // lr_vld masks the first cycle after reset so only a genuine LRCLK rise commits.
  always_comb begin
    e         = lr_vld && !lr_q && LRCLK;
    rdy       = (state == FILL) && !e && !RST;
    hs        = rdy && (ACT_SRC ? B_VALID : A_VALID);
    A_READY   = rdy && !ACT_SRC;
    B_READY   = rdy && ACT_SRC;
    state_nxt = state;
    if (e)
      state_nxt = FILL;
    else if (hs)
      state_nxt = FULL;
    com_l = '0;
    com_r = '0;
    if (MUTE) begin
      com_l = '0;
      com_r = '0;
    end else if (state == FULL) begin
      com_l = buf_l;
      com_r = buf_r;
    end else if (armed && UR_HOLD) begin
      com_l = last_l;
      com_r = last_r;
    end
  end

  always_ff @(posedge MCLKIN or posedge RST) begin
    if (RST)
      state <= FILL;
    else
      state <= state_nxt;
  end

  always_ff @(posedge MCLKIN or posedge RST) begin
    if (RST) begin
      lr_q     <= 1'b0;
      lr_vld   <= 1'b0;
      L_EN     <= 1'b0;
      R_EN     <= 1'b0;
      UNDERRUN <= 1'b0;
      L_DOUT   <= '0;
      R_DOUT   <= '0;
      buf_l    <= '0;
      buf_r    <= '0;
      last_l   <= '0;
      last_r   <= '0;
      armed    <= 1'b0;
      ACT_SRC  <= 1'b0;
      ur_cnt   <= '0;
    end else begin
      lr_q     <= LRCLK;
      lr_vld   <= 1'b1;
      L_EN     <= e;
      R_EN     <= e;
      UNDERRUN <= e && (state == FILL) && armed;
      if (hs) begin
        buf_l <= ACT_SRC ? B_L : A_L;
        buf_r <= ACT_SRC ? B_R : A_R;
        armed <= 1'b1;
      end
      if (e) begin
        L_DOUT  <= com_l;
        R_DOUT  <= com_r;
        ACT_SRC <= SRC_SEL;
        if (state == FULL) begin
          last_l <= buf_l;
          last_r <= buf_r;
        end else if (armed && (ur_cnt != '1)) begin
          ur_cnt <= ur_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_sched.sv
// Randomized bench for i2s_frame_sched: two instances (repeat-last and send-zeros
// underrun policy) checked every cycle against a frame-level pair/commit model.
module tb_i2s_frame_sched;

  logic        MCLKIN, RST, LRCLK, SRC_SEL, MUTE;
  logic        A_VALID, B_VALID;
  logic [15:0] A_L, A_R, B_L, B_R;
  logic        A_READY, B_READY, L_EN, R_EN, ACT_SRC, UNDERRUN;
  logic [15:0] L_DOUT, R_DOUT, UR_CNT;
  logic        A_READY0, B_READY0, L_EN0, R_EN0, ACT_SRC0, UNDERRUN0;
  logic [15:0] L_DOUT0, R_DOUT0, UR_CNT0;

  i2s_frame_sched #(.DW(16), .UR_HOLD(1'b1)) dut (
    .MCLKIN(MCLKIN), .RST(RST), .LRCLK(LRCLK), .SRC_SEL(SRC_SEL), .MUTE(MUTE),
    .A_VALID(A_VALID), .A_L(A_L), .A_R(A_R), .B_VALID(B_VALID), .B_L(B_L), .B_R(B_R),
    .A_READY(A_READY), .B_READY(B_READY), .L_EN(L_EN), .R_EN(R_EN),
    .L_DOUT(L_DOUT), .R_DOUT(R_DOUT), .ACT_SRC(ACT_SRC), .UNDERRUN(UNDERRUN), .UR_CNT(UR_CNT)
  );

  i2s_frame_sched #(.DW(16), .UR_HOLD(1'b0)) dut0 (
    .MCLKIN(MCLKIN), .RST(RST), .LRCLK(LRCLK), .SRC_SEL(SRC_SEL), .MUTE(MUTE),
    .A_VALID(A_VALID), .A_L(A_L), .A_R(A_R), .B_VALID(B_VALID), .B_L(B_L), .B_R(B_R),
    .A_READY(A_READY0), .B_READY(B_READY0), .L_EN(L_EN0), .R_EN(R_EN0),
    .L_DOUT(L_DOUT0), .R_DOUT(R_DOUT0), .ACT_SRC(ACT_SRC0), .UNDERRUN(UNDERRUN0), .UR_CNT(UR_CNT0)
  );

  initial MCLKIN = 1'b0;
  always #5 MCLKIN = ~MCLKIN;

  int unsigned errs = 0;
  int unsigned checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Stimulus shadows, applied at the falling edge by step()
  logic        s_rst = 1'b1, s_sel = 1'b0, s_mute = 1'b0, s_av = 1'b0, s_bv = 1'b0;
  logic [15:0] s_al = '0, s_ar = '0, s_bl = '0, s_br = '0;
  int unsigned lr_cnt = 0;
  int unsigned per = 16;

  // Reference model: a pending-pair queue plus the last committed pair
  typedef struct packed {logic [15:0] l; logic [15:0] r;} pair_t;
  pair_t       stage[$];
  pair_t       last;
  bit          armed, src, lr_known, prev_lr;
  int unsigned cnt;
  bit          x_en, x_ur;
  pair_t       x_hold, x_zero;

  task automatic model_reset();
    stage.delete();
    last = '0; armed = 0; src = 0; cnt = 0;
    x_en = 0; x_ur = 0; x_hold = '0; x_zero = '0;
    lr_known = 0; prev_lr = 0;
  endtask

  task automatic step();
    bit e, rdy;
    pair_t p;
    @(negedge MCLKIN);
    RST = s_rst; SRC_SEL = s_sel; MUTE = s_mute;
    A_VALID = s_av; A_L = s_al; A_R = s_ar;
    B_VALID = s_bv; B_L = s_bl; B_R = s_br;
    LRCLK = ((lr_cnt % per) >= (per / 2));
    lr_cnt++;
    #1;
    if (RST) model_reset();
    e   = !RST && lr_known && !prev_lr && LRCLK;
    rdy = !RST && (stage.size() == 0) && !e;
    chk("ready", {A_READY, B_READY, A_READY0, B_READY0}, {rdy && !src, rdy && src, rdy && !src, rdy && src});
    chk("strobe", {L_EN, R_EN, UNDERRUN, L_EN0, R_EN0, UNDERRUN0}, {x_en, x_en, x_ur, x_en, x_en, x_ur});
    chk("dout_hold", {L_DOUT, R_DOUT}, x_hold);
    chk("dout_zero", {L_DOUT0, R_DOUT0}, x_zero);
    chk("act_src", {ACT_SRC, ACT_SRC0}, {src, src});
    chk("ur_cnt", {UR_CNT, UR_CNT0}, {cnt[15:0], cnt[15:0]});
    if (!RST) begin
      x_en = 0; x_ur = 0;
      if (e) begin
        x_en = 1;
        if (stage.size() != 0) begin
          p = stage.pop_front();
          last = p; x_hold = p; x_zero = p;
        end else if (armed) begin
          x_ur = 1;
          if (cnt < 32'hFFFF) cnt++;
          x_hold = last; x_zero = '0;
        end else begin
          x_hold = '0; x_zero = '0;
        end
        if (MUTE) begin x_hold = '0; x_zero = '0; end
        src = SRC_SEL;
      end else if (rdy && (src ? B_VALID : A_VALID)) begin
        stage.push_back(src ? {B_L, B_R} : {A_L, A_R});
        armed = 1;
      end
      lr_known = 1;
      prev_lr  = LRCLK;
    end
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int unsigned n);
    s_rst = 1'b1;
    run(n);
    s_rst = 1'b0;
  endtask

  task automatic wait_full();
    for (int unsigned i = 0; i < 64 && stage.size() == 0; i++) step();
    chk("wait_full", {63'd0, stage.size() != 0}, 64'd1);
  endtask

  initial begin
    RST = 1'b1; LRCLK = 1'b0; SRC_SEL = 1'b0; MUTE = 1'b0;
    A_VALID = 1'b0; B_VALID = 1'b0; A_L = '0; A_R = '0; B_L = '0; B_R = '0;
    model_reset();

    // First pair from A before the first commit
    do_reset(3); lr_cnt = 0;
    s_av = 1; s_al = 16'h1234; s_ar = 16'hABCD;
    wait_full();
    s_av = 0;
    run(2 * per);

    // Three silent frames, one pair, then silence exercising both underrun policies
    do_reset(2); lr_cnt = 0;
    run(3 * per + 4);
    s_av = 1; s_al = 16'h5A5A; s_ar = 16'hC3C3;
    wait_full();
    s_av = 0;
    run(3 * per);

    // Source switch while A's pair is buffered
    s_av = 1; s_al = 16'h1111; s_ar = 16'h2222;
    wait_full();
    s_av = 0; s_sel = 1;
    s_bv = 1; s_bl = 16'h3333; s_br = 16'h4444;
    run(3 * per);

    // Mute with B active, then unmuted pairs
    s_bl = 16'h7FFF; s_br = 16'h8000; s_mute = 1;
    run(2 * per);
    s_mute = 0; s_bl = 16'h0F0F; s_br = 16'hF0F0;
    run(2 * per);
    s_bv = 0;

    // Randomized traffic
    for (int unsigned i = 0; i < 800; i++) begin
      s_av = ($urandom_range(0, 9) < 3);
      s_bv = ($urandom_range(0, 9) < 3);
      s_al = 16'($urandom); s_ar = 16'($urandom);
      s_bl = 16'($urandom); s_br = 16'($urandom);
      if ($urandom_range(0, 39) == 0) s_sel = ~s_sel;
      s_mute = ($urandom_range(0, 9) == 0);
      step();
    end
    s_av = 0; s_bv = 0; s_mute = 0;
    run(per);

    // Underrun counter saturation, preloaded near the top
    @(posedge MCLKIN);
    #2;
    force dut.ur_cnt = 16'hFFFD;
    force dut0.ur_cnt = 16'hFFFD;
    #1;
    release dut.ur_cnt;
    release dut0.ur_cnt;
    cnt = 32'hFFFD;
    run(6 * per);

    // Reset pulse while a pair is buffered
    s_sel = 0; s_av = 1; s_al = 16'hDEAD; s_ar = 16'hBEEF;
    run(per);
    wait_full();
    s_av = 0;
    do_reset(2);
    run(3 * per);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
